// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - M-stage single-cycle data access to req/addr_ok/data_ok bus bridge
//
// Purpose: turns the datapath's M-stage load/store into a request/addr_ok/data_ok
// bus transaction with one access outstanding. Freezes the pipeline (stall_o) while
// the access is in flight and holds the returned load word until the pipeline advances.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   mem_en_i / mem_wr_i       access valid / store (1) or load (0)
//   mem_wen_i / mem_size_i    store byte enables / load size (0=B, 1=H, 2=W)
//   mem_addr_i / mem_wdata_i  byte address / lane-aligned store data
//   mem_rdata_o               raw load word to the datapath
//   stall_o / pipe_stall_i    freeze request to F..M / stall from other sources
//   data_req .. data_wdata    bus request side
//   data_addr_ok, data_data_ok, data_rdata  bus acceptance and response
module dmem_bridge #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_en_i,
    input  logic          mem_wr_i,
    input  logic [3:0]    mem_wen_i,
    input  logic [1:0]    mem_size_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_wdata_i,
    output logic [DW-1:0] mem_rdata_o,
    output logic          stall_o,
    input  logic          pipe_stall_i,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] rdata_buf_q;
    logic [DW-1:0] rdata_buf_d;
    logic          req_raw;
    logic          resp_hit;
    logic [1:0]    store_size;

    // Response is only meaningful while waiting; data_ok elsewhere is ignored.
    assign resp_hit = (state_q == S_WAIT) && data_data_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rdata_buf_q <= '0;
        end else begin
            state_q     <= state_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_raw     = 1'b0;
        rdata_buf_d = rdata_buf_q;
        if (resp_hit) begin
            rdata_buf_d = data_rdata;
        end
        case (state_q)
            S_IDLE: begin
                req_raw = mem_en_i;
                if (mem_en_i) begin
                    state_d = data_addr_ok ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                // Completed even if mem_en_i drops; the pipeline is frozen here.
                req_raw = 1'b1;
                if (data_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_d = pipe_stall_i ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                // Access finished but pipeline held elsewhere; keep the word, issue nothing.
                if (!pipe_stall_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Store size follows the byte-enable pattern; irregular patterns fall back to a word.
    always_comb begin
        store_size = 2'd2;
        case (mem_wen_i)
            4'b1111:                            store_size = 2'd2;
            4'b0011, 4'b1100:                   store_size = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: store_size = 2'd0;
            default:                            store_size = 2'd2;
        endcase
    end

    // Request and stall are forced low while reset is held so the bus and
    // pipeline see a quiet bridge immediately, not only after the next edge.
    assign data_req    = rst & req_raw;
    assign stall_o     = rst & mem_en_i & (state_q != S_DONE) & ~resp_hit;
    assign data_wr     = mem_wr_i;
    assign data_size   = mem_wr_i ? store_size : mem_size_i;
    assign data_addr   = mem_addr_i;
    assign data_wdata  = mem_wdata_i;
    assign mem_rdata_o = resp_hit ? data_rdata : rdata_buf_q;

endmodule
